// File: rtl/disp_scan_mux.sv
// disp_scan_mux: scans four BCD digits onto one shared 7-segment decoder
// with a blanking guard between digits and blinking of masked digits.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   d0..d3         BCD digits (d0 rightmost on anode 0, d3 leftmost)
//   blink_mask     bit i set makes digit i blink
//   digit          currently scanned digit (4'hF if input not valid BCD)
//   an_n           active-low anode enables, at most one low at a time
//   dp_n           active-low decimal point, lit on digit 2
module disp_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] blink_mask,
    output logic [3:0] digit,
    output logic [3:0] an_n,
    output logic       dp_n
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam bit NOBLANK = (BLANK_CYCLES == 0);
    localparam int LB = NOBLANK ? 0 : BLANK_CYCLES - 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'(LB);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [SW-1:0] r_slot_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_vis;

    state_t        w_state_nxt;
    logic [1:0]    w_idx_nxt;
    logic [SW-1:0] w_cnt_nxt;
    logic [3:0]    w_digit_nxt;
    logic [3:0]    w_sel;
    logic          w_slot_end;
    logic          w_load;
    logic          w_vis_nxt;
    logic          w_sup;
    logic          w_lit;

    assign w_slot_end = (r_slot_cnt == SLOT_LAST);
    assign w_vis_nxt  = r_blink_vis ^ (r_blink_cnt == BLINK_LAST);

    // Slot sequencing. Without blanking, the BLANK state is only seen
    // straight out of reset and acts as the entry edge of slot 0.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_slot_cnt + 1'b1;
        if (w_slot_end) begin
            w_idx_nxt   = r_idx + 2'd1;
            w_cnt_nxt   = '0;
            w_state_nxt = NOBLANK ? ST_ON : ST_BLANK;
        end else if (r_state == ST_BLANK) begin
            if (NOBLANK) begin
                w_cnt_nxt   = r_slot_cnt;
                w_state_nxt = ST_ON;
            end else if (r_slot_cnt == BLANK_LAST) begin
                w_state_nxt = ST_ON;
            end
        end
    end

    // Digit source follows the slot being entered, so an unblanked
    // build picks up the next digit on the slot-change edge.
    always_comb begin
        unique case (w_idx_nxt)
            2'd0:    w_sel = d0;
            2'd1:    w_sel = d1;
            2'd2:    w_sel = d2;
            default: w_sel = d3;
        endcase
    end

    assign w_load = (r_state == ST_BLANK) || (NOBLANK && w_slot_end);

    always_comb begin
        w_digit_nxt = digit;
        if (w_load) begin
            w_digit_nxt = (w_sel > 4'd9) ? 4'hF : w_sel;
        end
    end

    assign w_sup = (w_digit_nxt == 4'hF)
                 || (blink_mask[w_idx_nxt] && !w_vis_nxt);
    assign w_lit = (w_state_nxt == ST_ON) && !w_sup;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_BLANK;
            r_idx       <= 2'd0;
            r_slot_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink_vis <= 1'b1;
            digit       <= 4'd0;
            an_n        <= 4'b1111;
            dp_n        <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_slot_cnt  <= w_cnt_nxt;
            r_blink_vis <= w_vis_nxt;
            r_blink_cnt <= (r_blink_cnt == BLINK_LAST) ? '0
                                                       : r_blink_cnt + 1'b1;
            digit       <= w_digit_nxt;
            an_n        <= w_lit ? ~(4'b0001 << w_idx_nxt) : 4'b1111;
            dp_n        <= !(w_lit && (w_idx_nxt == 2'd2));
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// tb_disp_scan_mux: randomized scoreboard bench for disp_scan_mux,
// run with and without the blanking guard against a slot-position model.
module tb_disp_scan_mux;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BD = 40;

    typedef struct {
        logic [3:0] dig;
        logic [3:0] an;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dv [4];
    logic [3:0] mask;
    logic [3:0] a_dig, a_an, b_dig, b_an;
    logic       a_dp, b_dp;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    logic [3:0] ea_dig = 4'd0;
    logic [3:0] eb_dig = 4'd0;

    always #5 clk = ~clk;

    disp_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_DIV(BD)) u_a (
        .clk(clk), .rst(rst),
        .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
        .blink_mask(mask),
        .digit(a_dig), .an_n(a_an), .dp_n(a_dp)
    );

    disp_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(0), .BLINK_DIV(BD)) u_b (
        .clk(clk), .rst(rst),
        .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
        .blink_mask(mask),
        .digit(b_dig), .an_n(b_an), .dp_n(b_dp)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] enc(input logic [3:0] v);
        return (v > 4'd9) ? 4'hF : v;
    endfunction

    // Expected outputs after edge number k (counted from reset release).
    // Position in the 4-slot frame comes from plain arithmetic on k.
    task automatic model(input int bc, input logic [3:0] cur,
                         output logic [3:0] nd, output exp_t e);
        int  off, pos, idx, s;
        bit  load, on, vis, sup;
        off  = (bc == 0) ? 1 : 0;
        pos  = (k + 1 - off) % (4 * RD);
        idx  = pos / RD;
        s    = pos % RD;
        load = (bc == 0) ? (s == 0) : (s >= 1 && s <= bc);
        nd   = load ? enc(dv[idx]) : cur;
        on   = (s >= bc);
        vis  = (((k + 1) / BD) % 2) == 0;
        sup  = (nd == 4'hF) || (mask[idx] && !vis);
        e.dig = nd;
        e.an  = (on && !sup) ? 4'(~(4'b0001 << idx)) : 4'hF;
        e.dp  = !(on && !sup && idx == 2);
    endtask

    task automatic tick();
        exp_t ea, eb;
        logic [3:0] na, nb;
        @(posedge clk);
        model(BC, ea_dig, na, ea);
        model(0, eb_dig, nb, eb);
        ea_dig = na;
        eb_dig = nb;
        qa.push_back(ea);
        qb.push_back(eb);
        k++;
        #2;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_digit", a_dig, e.dig);
            chk("a_an_n", a_an, e.an);
            chk("a_dp_n", a_dp, e.dp);
            chk("a_onehot", ($countones(~a_an) <= 1), 1);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_digit", b_dig, e.dig);
            chk("b_an_n", b_an, e.an);
            chk("b_dp_n", b_dp, e.dp);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_a_an"}, a_an, 4'hF);
        chk({tag, "_a_dp"}, a_dp, 1);
        chk({tag, "_a_dig"}, a_dig, 0);
        chk({tag, "_b_an"}, b_an, 4'hF);
        chk({tag, "_b_dp"}, b_dp, 1);
        chk({tag, "_b_dig"}, b_dig, 0);
    endtask

    initial begin
        dv[0] = 4'd4; dv[1] = 4'd3; dv[2] = 4'd2; dv[3] = 4'd1;
        mask = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset("rst0");
        rst = 1'b0;
        k = 0;

        repeat (64) tick();

        while ((k % 32) != 4) tick();
        dv[0] = 4'd7;
        repeat (40) tick();

        dv[1] = 4'hA;
        repeat (40) tick();
        dv[1] = 4'd5;

        mask = 4'b0001;
        repeat (100) tick();
        mask = 4'b0000;

        repeat (600) begin
            tick();
            if ($urandom_range(0, 7) == 0)
                dv[$urandom_range(0, 3)] = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 15) == 0)
                mask = 4'($urandom_range(0, 15));
        end

        mask = 4'b0000;
        dv[2] = 4'd6;
        repeat (40) tick();
        while ((k % 32) != 20) tick();
        @(negedge clk);
        #1;
        chk("pre_rst_a_an", a_an, 4'b1011);
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        ea_dig = 4'd0;
        eb_dig = 4'd0;
        repeat (40) tick();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
